// File: rtl/cpri_tx_pkt_packer_if.sv
// cpri_tx_pkt_packer_if: sample-in / packet-out bundle.
// master drives samples and observes packets; slave is the packer.
interface cpri_tx_pkt_packer_if;
  logic [31:0] i_din;
  logic        i_din_vld;
  logic        o_din_rdy;
  logic [31:0] o_dout;
  logic        o_dout_vld;
  logic        o_sop;
  logic        o_eop;
  logic [7:0]  o_seq;

  modport master (
    output i_din,
    output i_din_vld,
    input  o_din_rdy,
    input  o_dout,
    input  o_dout_vld,
    input  o_sop,
    input  o_eop,
    input  o_seq
  );

  modport slave (
    input  i_din,
    input  i_din_vld,
    output o_din_rdy,
    output o_dout,
    output o_dout_vld,
    output o_sop,
    output o_eop,
    output o_seq
  );
endinterface

// File: rtl/cpri_tx_pkt_packer.sv
// cpri_tx_pkt_packer: FIFO-buffered IQ packetiser (header + payload).
// Define CPRI_TX_PKT_CHKSUM_EN to append an XOR checksum trailer word.
module cpri_tx_pkt_packer #(
  parameter int PKT_LEN = 16,
  parameter int FIFO_AW = 5
) (
  input logic                clk,
  input logic                rst_n,
  cpri_tx_pkt_packer_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C =
    (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LEN_C =
    (FIFO_AW+1)'(PKT_LEN);
  localparam logic [7:0] LEN8 = 8'(PKT_LEN);
  localparam logic [7:0] LAST = 8'(PKT_LEN-1);

`ifdef CPRI_TX_PKT_CHKSUM_EN
  typedef enum logic [1:0] {
    IDLE, HDR, PAYLOAD, TRL
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, HDR, PAYLOAD
  } state_t;
`endif

  state_t state;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               run_q;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        rd_data;

  logic [7:0]  seq;
  logic [7:0]  idx;
  logic [31:0] dout_q;
  logic        vld_q;
  logic        sop_q;
  logic        eop_q;
`ifdef CPRI_TX_PKT_CHKSUM_EN
  logic [31:0] chk;
`endif

  // run_q keeps the FIFO closed until the first clock out of reset
  assign bus.o_din_rdy = run_q & (count != DEPTH_C);
  assign wr_en   = bus.i_din_vld & bus.o_din_rdy;
  assign rd_en   = (state == PAYLOAD);
  assign rd_data = mem[rd_ptr];

  assign bus.o_dout     = dout_q;
  assign bus.o_dout_vld = vld_q;
  assign bus.o_sop      = sop_q;
  assign bus.o_eop      = eop_q;
  assign bus.o_seq      = seq;

  // sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.i_din;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // packet FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      seq    <= 8'd0;
      idx    <= 8'd0;
      dout_q <= 32'd0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
`ifdef CPRI_TX_PKT_CHKSUM_EN
      chk    <= 32'd0;
`endif
    end else begin
      vld_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count >= LEN_C) state <= HDR;
        end
        HDR: begin
          dout_q <= {8'hA5, seq, 8'h00, LEN8};
          vld_q  <= 1'b1;
          sop_q  <= 1'b1;
          idx    <= 8'd0;
          state  <= PAYLOAD;
        end
        PAYLOAD: begin
          dout_q <= rd_data;
          vld_q  <= 1'b1;
          idx    <= idx + 8'd1;
`ifdef CPRI_TX_PKT_CHKSUM_EN
          chk <= (idx == 8'd0) ? rd_data
                               : (chk ^ rd_data);
          if (idx == LAST) state <= TRL;
`else
          if (idx == LAST) begin
            eop_q <= 1'b1;
            seq   <= seq + 8'd1;
            state <= IDLE;
          end
`endif
        end
`ifdef CPRI_TX_PKT_CHKSUM_EN
        TRL: begin
          dout_q <= chk;
          vld_q  <= 1'b1;
          eop_q  <= 1'b1;
          seq    <= seq + 8'd1;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpri_tx_pkt_packer.sv
// tb_cpri_tx_pkt_packer: randomized scenarios vs packet-stream model.
// Model: input word queue, seq counter, XOR trailer when enabled.
module tb_cpri_tx_pkt_packer;

  localparam int L     = 16;
  localparam int DEPTH = 32;
`ifdef CPRI_TX_PKT_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpri_tx_pkt_packer_if bus ();

  cpri_tx_pkt_packer #(
    .PKT_LEN(L),
    .FIFO_AW(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          mon_en = 1'b0;
  int          pos = 0;
  logic [7:0]  exp_seq = 8'd0;
  logic [31:0] acc = 32'd0;
  logic [31:0] mw;
  int          pkts = 0;
  int          idle_run = 0;
  bit          strict_gap = 1'b0;
  logic [31:0] hdr_seen = 32'd0;
  bit          acc_b;

  // stream scoreboard: every output cycle against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_dout_vld === 1'b1) begin
        if (pos == 0) begin
          checks++;
          if (bus.o_dout !== {8'hA5, exp_seq, 8'h00, 8'(L)} ||
              bus.o_sop !== 1'b1 || bus.o_eop !== 1'b0) begin
            errors++;
            $display("FAIL hdr: got %h sop %b eop %b, want %h sop 1 eop 0",
              bus.o_dout, bus.o_sop, bus.o_eop,
              {8'hA5, exp_seq, 8'h00, 8'(L)});
          end
          if (strict_gap) begin
            checks++;
            if (idle_run != 1) begin
              errors++;
              $display("FAIL gap: got %0d idle cycles, want 1", idle_run);
            end
          end
          hdr_seen = bus.o_dout;
          acc = 32'd0;
          pos = 1;
        end else if (pos <= L) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL payload: got %h with model queue empty", bus.o_dout);
          end else begin
            mw = q.pop_front();
            acc = acc ^ mw;
            if (bus.o_dout !== mw || bus.o_sop !== 1'b0 ||
                bus.o_eop !== (pos == L && !CHK)) begin
              errors++;
              $display("FAIL payload[%0d]: got %h sop %b eop %b, want %h sop 0 eop %b",
                pos, bus.o_dout, bus.o_sop, bus.o_eop, mw, (pos == L && !CHK));
            end
          end
          pos++;
          if (!CHK && pos > L) begin
            pos = 0;
            exp_seq = exp_seq + 8'd1;
            pkts++;
          end
        end else begin
          checks++;
          if (bus.o_dout !== acc || bus.o_sop !== 1'b0 || bus.o_eop !== 1'b1) begin
            errors++;
            $display("FAIL trailer: got %h sop %b eop %b, want %h sop 0 eop 1",
              bus.o_dout, bus.o_sop, bus.o_eop, acc);
          end
          pos = 0;
          exp_seq = exp_seq + 8'd1;
          pkts++;
        end
        idle_run = 0;
      end else begin
        checks++;
        if (pos != 0 || bus.o_sop !== 1'b0 || bus.o_eop !== 1'b0) begin
          errors++;
          $display("FAIL idle: got vld 0 sop %b eop %b at pos %0d, want pos 0 sop 0 eop 0",
            bus.o_sop, bus.o_eop, pos);
        end
        idle_run++;
      end
      checks++;
      if (bus.o_seq !== exp_seq) begin
        errors++;
        $display("FAIL o_seq: got %0d, want %0d", bus.o_seq, exp_seq);
      end
      checks++;
      if (bus.o_din_rdy !== (q.size() != DEPTH)) begin
        errors++;
        $display("FAIL o_din_rdy: got %b, want %b (level %0d)",
          bus.o_din_rdy, (q.size() != DEPTH), q.size());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, output bit a);
    @(negedge clk);
    bus.i_din_vld = v;
    bus.i_din = d;
    #1;
    a = v && (bus.o_din_rdy === 1'b1);
    if (a) q.push_back(d);
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #2;
      if (pos == 0 && q.size() < L) ok = 1'b1;
    end
  endtask

  task automatic wait_pkts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #2;
      if (pkts >= target && pos == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    bus.i_din = 32'd0;
    bus.i_din_vld = 1'b0;
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus.o_dout !== 32'd0 || bus.o_dout_vld !== 1'b0 || bus.o_sop !== 1'b0 ||
        bus.o_eop !== 1'b0 || bus.o_seq !== 8'd0 || bus.o_din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got dout %h vld %b sop %b eop %b seq %0d rdy %b, want all 0",
        bus.o_dout, bus.o_dout_vld, bus.o_sop, bus.o_eop, bus.o_seq, bus.o_din_rdy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.o_din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rdy_before_clk: got %b, want 0", bus.o_din_rdy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_clk: got %b, want 1", bus.o_din_rdy);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    int start = pkts;
    for (int i = 1; i <= 16; i++) drive(1'b1, 32'(i), acc_b);
    drive(1'b0, 32'd0, acc_b);
    wait_pkts(start + 1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: got %0d packets, want %0d", pkts - start, 1);
    end
    checks++;
    if (hdr_seen !== 32'hA500_0010) begin
      errors++;
      $display("FAIL basic_hdr: got %h, want a5000010", hdr_seen);
    end
    checks++;
    if (bus.o_seq !== 8'd1) begin
      errors++;
      $display("FAIL basic_seq: got %0d, want 1", bus.o_seq);
    end
  endtask

  task automatic test_threshold;
    bit seen = 1'b0;
    for (int i = 0; i < L - 1; i++) drive(1'b1, $urandom, acc_b);
    drive(1'b0, 32'd0, acc_b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_dout_vld !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL below_threshold: got vld 1 with %0d words, want 0", L - 1);
    end
    drive(1'b1, $urandom, acc_b);
    @(negedge clk);
    bus.i_din_vld = 1'b0;
    checks++;
    if (bus.o_dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL hdr_lat1: got vld %b, want 0", bus.o_dout_vld);
    end
    @(negedge clk);
    checks++;
    if (bus.o_dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL hdr_lat2: got vld %b, want 0", bus.o_dout_vld);
    end
    @(negedge clk);
    checks++;
    if (bus.o_dout_vld !== 1'b1 || bus.o_sop !== 1'b1) begin
      errors++;
      $display("FAIL hdr_lat3: got vld %b sop %b, want 1 1", bus.o_dout_vld, bus.o_sop);
    end
  endtask

  task automatic test_fill;
    bit ok;
    bit saw_full = 1'b0;
    for (int i = 0; i < 1000 && !saw_full; i++) begin
      drive(1'b1, $urandom, acc_b);
      if (bus.o_din_rdy === 1'b0) saw_full = 1'b1;
    end
    repeat (20) drive(1'b1, $urandom, acc_b);
    drive(1'b0, 32'd0, acc_b);
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL fill_full: got rdy never 0, want 0 at level %0d", DEPTH);
    end
    wait_quiet(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_drain: got level %0d pos %0d, want level < %0d pos 0",
        q.size(), pos, L);
    end
  endtask

  task automatic test_continuous;
    bit ok;
    int start = pkts;
    for (int i = 0; i < 8000 && pkts < start + 300; i++) begin
      drive(1'b1, $urandom, acc_b);
      if (pkts >= start + 1) strict_gap = 1'b1;
    end
    strict_gap = 1'b0;
    drive(1'b0, 32'd0, acc_b);
    checks++;
    if (pkts < start + 300) begin
      errors++;
      $display("FAIL continuous: got %0d packets, want 300", pkts - start);
    end
    wait_quiet(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL continuous_drain: got level %0d pos %0d, want level < %0d pos 0",
        q.size(), pos, L);
    end
  endtask

  task automatic test_random;
    bit ok;
    int start = pkts;
    int lvl0 = q.size();
    int n_acc = 0;
    int want;
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, $urandom, acc_b);
      if (acc_b) n_acc++;
    end
    drive(1'b0, 32'd0, acc_b);
    wait_quiet(1000, ok);
    want = (lvl0 + n_acc) / L;
    checks++;
    if (!ok || pkts - start != want) begin
      errors++;
      $display("FAIL random_pkts: got %0d packets (quiet %b), want %0d",
        pkts - start, ok, want);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    bit hit = 1'b0;
    int start;
    for (int i = 0; i < 300 && !hit; i++) begin
      drive(1'b1, $urandom, acc_b);
      if (pos == 8) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrst_reach: got pos %0d, want 8", pos);
    end
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    bus.i_din_vld = 1'b0;
    #1;
    checks++;
    if (bus.o_dout !== 32'd0 || bus.o_dout_vld !== 1'b0 || bus.o_sop !== 1'b0 ||
        bus.o_eop !== 1'b0 || bus.o_seq !== 8'd0 || bus.o_din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got dout %h vld %b sop %b eop %b seq %0d rdy %b, want all 0",
        bus.o_dout, bus.o_dout_vld, bus.o_sop, bus.o_eop, bus.o_seq, bus.o_din_rdy);
    end
    q.delete();
    pos = 0;
    exp_seq = 8'd0;
    idle_run = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_dout_vld !== 1'b0 || bus.o_eop !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold: got vld %b eop %b, want 0 0",
          bus.o_dout_vld, bus.o_eop);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    start = pkts;
    for (int i = 0; i < L; i++) drive(1'b1, $urandom, acc_b);
    drive(1'b0, 32'd0, acc_b);
    wait_pkts(start + 1, 200, ok);
    checks++;
    if (!ok || hdr_seen !== 32'hA500_0010) begin
      errors++;
      $display("FAIL midrst_hdr: got %h (done %b), want a5000010", hdr_seen, ok);
    end
    checks++;
    if (bus.o_seq !== 8'd1) begin
      errors++;
      $display("FAIL midrst_seq: got %0d, want 1", bus.o_seq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_fill();
    test_continuous();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
